spiker_step_sequencer: RTL
==========================

// Module: spiker_step_sequencer
// PURPOSE
//  Sequences multi-timestep SNN inference over the spike register file. For each timestep it
//  pulses sample_o into the spike reader, which snapshots the spike registers into the
//  accelerator input. It then launches the accelerator with a valid/ready handshake and waits
//  for step completion, with a timeout. It counts timesteps, flags run done/error and reports
//  status back to the register file. It sits between the register-file control fields and the
//  spike reader / accelerator.
// PARAMETERS
//  STEP_W    16  width of timestep count (n_steps_i, step_cnt_o)
//  TIMEOUT_W 16  width of per-step completion timeout (timeout_i, internal timer)
// PORTS
//  clk_i        in   1          clock; all logic on rising edge
//  rst_i        in   1          synchronous, active-high reset
//  start_i      in   1          run request pulse (reg write); honoured only in IDLE
//  abort_i      in   1          abort request; honoured in any state
//  n_steps_i    in   STEP_W     timesteps per run; latched on accepted start
//  timeout_i    in   TIMEOUT_W  max cycles in WAIT_DONE; 0 = timeout disabled; latched on start
//  sample_o     out  1          one-cycle snapshot strobe to spike reader
//  snn_valid_o  out  1          step launch request to accelerator
//  snn_ready_i  in   1          accelerator accepts launch
//  snn_done_i   in   1          accelerator step-complete pulse
//  busy_o       out  1          run in progress (state != IDLE)
//  step_cnt_o   out  STEP_W     timesteps completed in current/last run
//  done_o       out  1          one-cycle run-complete pulse
//  err_o        out  1          sticky timeout error
// BEHAVIOUR
//  Reset (rst_i=1 at edge):
//  - state=IDLE; all outputs 0; step_cnt=0; latched n_steps/timeout=0.
//  - Reset mid-run discards the run; no done_o.
//  All outputs are decoded from registered state/counters; no input->output comb path.
//  FSM:
//  - IDLE: start_i with n_steps_i!=0 -> latch n_steps/timeout; step_cnt:=0; err:=0; ->SAMPLE.
//    start_i with n_steps_i==0 -> err:=0, done_o=1 next cycle, stay IDLE.
//  - SAMPLE: sample_o=1 (exactly 1 cycle). ->LAUNCH. The reader captures data at the same edge.
//  - LAUNCH: snn_valid_o=1 until snn_valid_o&&snn_ready_i; on handshake timer:=0, ->WAIT_DONE.
//    Do not drop valid before ready.
//  - WAIT_DONE: timer+=1 per cycle (saturating).
//    - snn_done_i: step_cnt+=1; if step_cnt+1==n_steps ->DONE else ->SAMPLE.
//    - else if timeout!=0 && timer==timeout-1: err:=1, ->IDLE (no done_o).
//    - done and timeout in same cycle: done wins.
//  - DONE: done_o=1 one cycle; ->IDLE; step_cnt holds final value.
//  Latency: start at edge t -> sample_o high in cycle t+1 -> snn_valid_o from t+2.
//  A ready response in the same cycle gives step turnaround = done edge -> next sample_o
//  one cycle later.
//  Boundaries:
//  - start_i while busy_o: ignored, latched values unchanged.
//  - abort_i (priority over start_i and all transitions): ->IDLE next edge; valid/sample drop;
//    step_cnt holds; no done_o; err unchanged.
//  - snn_done_i/snn_ready_i outside WAIT_DONE/LAUNCH: ignored.
//  - n_steps = 2^STEP_W-1: step_cnt reaches max without wrap.
//  - err_o clears only on accepted start or reset.
// TESTING
//  1 Reset: hold rst_i 2 cycles mid-run -> all outputs 0, state IDLE, no done_o.
//  2 n_steps=3, ready tied 1, done 4 cycles after launch -> exactly 3 sample_o pulses,
//    step_cnt 1,2,3, one done_o, busy_o falls after done.
//  3 Backpressure: ready low 5 cycles -> snn_valid_o held 6 cycles, single launch per step.
//  4 timeout=10, done never asserted -> err_o=1 after 10 WAIT_DONE cycles, busy_o=0,
//    no done_o; next start clears err_o.
//  5 abort_i in LAUNCH at step 2 of 4 -> IDLE next cycle, step_cnt=1, no done_o;
//    start_i during run ignored.
//  6 start with n_steps=0 -> done_o pulse, no sample_o; done and timeout same cycle -> step counted.

Source files
------------

// File: rtl/spiker_step_sequencer.sv
// ---------------------------------------------------------------------------
// spiker_step_sequencer
//
// Runs a multi-timestep SNN inference. For each timestep the sequencer strobes
// the spike reader so it snapshots the spike registers, launches one
// accelerator step with a valid/ready handshake, and waits for the step
// completion pulse. An optional timeout bounds the wait. The sequencer counts
// completed timesteps and reports busy / done / error status to the register
// file.
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous active-high reset
//   start_i      run request pulse, accepted only while idle
//   abort_i      abort request, accepted in any state (highest priority)
//   n_steps_i    timesteps per run, latched on an accepted start
//   timeout_i    max cycles spent waiting for a step (0 = no timeout)
//   sample_o     one-cycle snapshot strobe to the spike reader
//   snn_valid_o  step launch request to the accelerator
//   snn_ready_i  accelerator accepts the launch
//   snn_done_i   accelerator step-complete pulse
//   busy_o       run in progress
//   step_cnt_o   timesteps completed in the current / last run
//   done_o       one-cycle run-complete pulse
//   err_o        sticky timeout error
//
// Every output is decoded from registered state, so no input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module spiker_step_sequencer #(
  parameter int STEP_W    = 16,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [STEP_W-1:0]    n_steps_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  output logic                 sample_o,
  output logic                 snn_valid_o,
  input  logic                 snn_ready_i,
  input  logic                 snn_done_i,
  output logic                 busy_o,
  output logic [STEP_W-1:0]    step_cnt_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SAMPLE    = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TIMER_MAX = {TIMEOUT_W{1'b1}};

  state_t               state_reg,     state_next;
  logic [STEP_W-1:0]    n_steps_reg,   n_steps_next;
  logic [TIMEOUT_W-1:0] timeout_reg,   timeout_next;
  logic [STEP_W-1:0]    step_cnt_reg,  step_cnt_next;
  logic [TIMEOUT_W-1:0] timer_reg,     timer_next;
  logic                 err_reg,       err_next;
  // A start with zero timesteps completes immediately: the run-complete
  // pulse comes from this flag instead of a trip through ST_DONE.
  logic                 zero_done_reg, zero_done_next;

  logic [STEP_W-1:0]    step_cnt_inc;
  logic                 timed_out;

  // step_cnt is always below n_steps while waiting, so the increment can
  // never wrap even when n_steps is the all-ones maximum.
  assign step_cnt_inc = step_cnt_reg + STEP_W'(1);
  assign timed_out    = (timeout_reg != '0) &&
                        (timer_reg == timeout_reg - TIMEOUT_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      n_steps_reg   <= '0;
      timeout_reg   <= '0;
      step_cnt_reg  <= '0;
      timer_reg     <= '0;
      err_reg       <= 1'b0;
      zero_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      n_steps_reg   <= n_steps_next;
      timeout_reg   <= timeout_next;
      step_cnt_reg  <= step_cnt_next;
      timer_reg     <= timer_next;
      err_reg       <= err_next;
      zero_done_reg <= zero_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    n_steps_next   = n_steps_reg;
    timeout_next   = timeout_reg;
    step_cnt_next  = step_cnt_reg;
    timer_next     = timer_reg;
    err_next       = err_reg;
    zero_done_next = 1'b0;

    if (abort_i) begin
      // Abort beats every other transition; counters and error hold.
      state_next = ST_IDLE;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            err_next = 1'b0;
            if (n_steps_i != '0) begin
              n_steps_next  = n_steps_i;
              timeout_next  = timeout_i;
              step_cnt_next = '0;
              state_next    = ST_SAMPLE;
            end else begin
              zero_done_next = 1'b1;
            end
          end
        end

        ST_SAMPLE: begin
          state_next = ST_LAUNCH;
        end

        ST_LAUNCH: begin
          if (snn_ready_i) begin
            timer_next = '0;
            state_next = ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (timer_reg != TIMER_MAX) begin
            timer_next = timer_reg + TIMEOUT_W'(1);
          end
          // A completion arriving on the timeout cycle still counts.
          if (snn_done_i) begin
            step_cnt_next = step_cnt_inc;
            state_next    = (step_cnt_inc == n_steps_reg) ? ST_DONE : ST_SAMPLE;
          end else if (timed_out) begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end
        end

        ST_DONE: begin
          state_next = ST_IDLE;
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign sample_o    = (state_reg == ST_SAMPLE);
  assign snn_valid_o = (state_reg == ST_LAUNCH);
  assign busy_o      = (state_reg != ST_IDLE);
  assign step_cnt_o  = step_cnt_reg;
  assign done_o      = (state_reg == ST_DONE) || zero_done_reg;
  assign err_o       = err_reg;

endmodule
